counter_checker: RTL and testbench

// - Passive reader of the counter interface: observes the same control/data signals the stimulus drives and checks data_out.
// - Holds a cycle-accurate reference model of the load/up-down counter and flags every data_out mismatch.
// - Sits beside the counter DUT on the same clk/reset; drives nothing on the counter interface.
// - Exports a mismatch pulse, a saturating error count and a halt flag for the bench or status registers.

---
 rtl/counter_checker.sv | 162 ++++++++++++++++
 tb/tb_counter_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Passive cycle-accurate checker for a load/up-down counter: mirrors the counter rule and flags data_out mismatches.
// Optional first-mismatch history (exp/act/cycle stamp) is built when COUNTER_CHECKER_HIST_EN is defined.
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int STOP_ON_ERR = 0,
  parameter int CYC_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 check_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 load,
  input  logic                 up_down,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     data_out,
  output logic                 checking,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 halted,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_act,
  output logic [CYC_W-1:0]     first_err_cycle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_exp;
  logic [WIDTH-1:0]     w_exp_nxt;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_fail;
  logic                 r_mismatch;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Counter rule: load beats enable; arithmetic wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] f_next(
    input logic [WIDTH-1:0] base,
    input logic             ld,
    input logic [WIDTH-1:0] din,
    input logic             en,
    input logic             up
  );
    if (ld)
      return din;
    else if (en)
      return up ? (base + DATA_ONE) : (base - DATA_ONE);
    else
      return base;
  endfunction

  // An unknown bit in data_out must count as a failure, so the reduction is
  // tested with !== rather than a plain inequality.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_fail = 1'b0;
    w_diff = data_out ^ r_exp;
    if (r_state == S_CHECK)
      w_fail = ((|w_diff) !== 1'b0);
  end

  // In IDLE the model re-seeds from the observed counter so entering CHECK never raises a false error.
  always_comb begin
    w_exp_nxt = r_exp;
    case (r_state)
      S_IDLE:  w_exp_nxt = f_next(data_out, load, data_in, enable, up_down);
      S_CHECK: w_exp_nxt = f_next(r_exp, load, data_in, enable, up_down);
      default: w_exp_nxt = r_exp;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (check_en)
          w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_fail && (STOP_ON_ERR != 0))
          w_state_nxt = S_HALT;
        else if (!check_en)
          w_state_nxt = S_IDLE;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    checking = (r_state == S_CHECK);
    halted   = (r_state == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp       <= '0;
      r_mismatch  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_exp      <= w_exp_nxt;
      r_mismatch <= w_fail;
      if (w_fail && (r_err_count != {ERR_CNT_W{1'b1}}))
        r_err_count <= r_err_count + ERR_ONE;
    end
  end

  assign mismatch  = r_mismatch;
  assign err_count = r_err_count;

`ifdef COUNTER_CHECKER_HIST_EN
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CYC_W-1:0] r_cyc;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_act;
  logic [CYC_W-1:0] r_first_cyc;

  // err_count is still zero exactly on the first failing edge since the last reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc       <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_first_cyc <= '0;
    end else begin
      if (r_state == S_CHECK)
        r_cyc <= r_cyc + CYC_ONE;
      if (w_fail && (r_err_count == '0)) begin
        r_first_exp <= r_exp;
        r_first_act <= data_out;
        r_first_cyc <= r_cyc;
      end
    end
  end

  assign first_err_exp   = r_first_exp;
  assign first_err_act   = r_first_act;
  assign first_err_cycle = r_first_cyc;
`else
  assign first_err_exp   = '0;
  assign first_err_act   = '0;
  assign first_err_cycle = '0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a bench-side counter drives data_out (with injected faults) into a free-running
// and a stop-on-error instance; a per-instance behavioural model predicts every output.
module tb_counter_checker;

  localparam int W  = 4;
  localparam int EW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          check_en;
  logic          load;
  logic          up_down;
  logic          enable;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic [1:0]    checking;
  logic [1:0]    mismatch;
  logic [1:0]    halted;
  logic [EW-1:0] err_count [2];
  logic [W-1:0]  fe_exp    [2];
  logic [W-1:0]  fe_act    [2];
  logic [CW-1:0] fe_cyc    [2];

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .ERR_CNT_W(EW), .STOP_ON_ERR(0), .CYC_W(CW)) u_dut_run (
    .clk(clk), .reset(reset), .check_en(check_en), .data_in(data_in), .load(load),
    .up_down(up_down), .enable(enable), .data_out(data_out),
    .checking(checking[0]), .mismatch(mismatch[0]), .err_count(err_count[0]), .halted(halted[0]),
    .first_err_exp(fe_exp[0]), .first_err_act(fe_act[0]), .first_err_cycle(fe_cyc[0])
  );

  counter_checker #(.WIDTH(W), .ERR_CNT_W(EW), .STOP_ON_ERR(1), .CYC_W(CW)) u_dut_stop (
    .clk(clk), .reset(reset), .check_en(check_en), .data_in(data_in), .load(load),
    .up_down(up_down), .enable(enable), .data_out(data_out),
    .checking(checking[1]), .mismatch(mismatch[1]), .err_count(err_count[1]), .halted(halted[1]),
    .first_err_exp(fe_exp[1]), .first_err_act(fe_act[1]), .first_err_cycle(fe_cyc[1])
  );

  // Model state: mode 0 idle, 1 check, 2 halt; index 1 is the stop-on-error instance.
  int ctr;
  int m_st [2];
  int m_exp [2];
  int m_err [2];
  bit m_mis [2];
  bit m_have [2];
  int m_fe_exp [2];
  int m_fe_act [2];
  int m_fe_cyc [2];
  int m_cyc [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    else
      n_pass++;
  endtask

  function automatic int nv(input int base);
    if (load) return int'(data_in);
    if (enable) return up_down ? (base + 1) % 16 : (base + 15) % 16;
    return base;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0;  m_exp[k] = 0;  m_err[k] = 0;  m_mis[k] = 1'b0;  m_have[k] = 1'b0;
      m_fe_exp[k] = 0;  m_fe_act[k] = 0;  m_fe_cyc[k] = 0;  m_cyc[k] = 0;
    end
    ctr = 0;
  endtask

  task automatic model_step();
    bit fail;
    for (int k = 0; k < 2; k++) begin
      fail = (m_st[k] == 1) && (data_out !== 4'(m_exp[k]));
      m_mis[k] = fail;
      case (m_st[k])
        0: begin
          m_exp[k] = nv(int'(data_out));
          if (check_en) m_st[k] = 1;
        end
        1: begin
          if (fail) begin
            if (!m_have[k]) begin
              m_have[k]   = 1'b1;
              m_fe_exp[k] = m_exp[k];
              m_fe_act[k] = int'(data_out);
              m_fe_cyc[k] = m_cyc[k];
            end
            if (m_err[k] < 255) m_err[k]++;
          end
          m_cyc[k] = (m_cyc[k] + 1) % 65536;
          m_exp[k] = nv(m_exp[k]);
          if (fail && k == 1) m_st[k] = 2;
          else if (!check_en) m_st[k] = 0;
        end
        default: ;
      endcase
    end
    ctr = nv(ctr);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check("mismatch", 32'(mismatch[k]), 32'(m_mis[k]));
      check("err_count", 32'(err_count[k]), 32'(m_err[k]));
      check("checking", 32'(checking[k]), 32'(m_st[k] == 1));
      check("halted", 32'(halted[k]), 32'(m_st[k] == 2));
`ifdef COUNTER_CHECKER_HIST_EN
      check("first_err_exp", 32'(fe_exp[k]), 32'(m_fe_exp[k]));
      check("first_err_act", 32'(fe_act[k]), 32'(m_fe_act[k]));
      check("first_err_cycle", 32'(fe_cyc[k]), 32'(m_fe_cyc[k]));
`else
      check("first_err_tied", {fe_exp[k], fe_act[k], 8'h00, fe_cyc[k]}, 32'h0);
`endif
    end
  endtask

  // One clock: drive on the falling edge, predict, then compare just after the rising edge.
  task automatic drive(input bit ce, input bit ld, input logic [3:0] din, input bit en, input bit up,
                       input logic [3:0] err_mask, input bit make_x);
    @(negedge clk);
    check_en = ce;  load = ld;  data_in = din;  enable = en;  up_down = up;
    if (make_x && m_st[0] != 0 && m_st[1] != 0)
      data_out = 4'bxxxx;
    else
      data_out = 4'(ctr) ^ err_mask;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1;  check_en = 1'b0;  load = 1'b0;  up_down = 1'b0;  enable = 1'b0;
    data_in = '0;  data_out = '0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Count up through the F->0 wrap.
    repeat (20) drive(1, 0, 4'h0, 1, 1, 4'h0, 0);

    // Load 3 with enable high, then count down past zero.
    drive(1, 1, 4'h3, 1, 1, 4'h0, 0);
    repeat (5) drive(1, 0, 4'h0, 1, 0, 4'h0, 0);

    // Expected 5, observed 7.
    drive(1, 1, 4'h5, 0, 0, 4'h0, 0);
    drive(1, 0, 4'h0, 0, 0, 4'h2, 0);
    drive(1, 0, 4'h0, 0, 0, 4'h0, 0);
    check("err_one", 32'(err_count[0]), 32'd1);
    check("stop_halted", {31'd0, halted[1]}, 32'd1);
    check("stop_not_checking", {31'd0, checking[1]}, 32'd0);
`ifdef COUNTER_CHECKER_HIST_EN
    check("first_exp_5", 32'(fe_exp[0]), 32'h5);
    check("first_act_7", 32'(fe_act[0]), 32'h7);
`endif

    // Unknown value on data_out while checking.
    drive(1, 0, 4'h0, 1, 1, 4'h0, 1);
    drive(1, 0, 4'h0, 1, 1, 4'h0, 0);
    drive(1, 0, 4'h0, 1, 1, 4'h0, 0);

    // Random traffic with occasional check_en drops and injected faults.
    for (int i = 0; i < 400; i++) begin
      automatic bit         ce   = ($urandom_range(0, 9) != 0);
      automatic bit         ld   = ($urandom_range(0, 7) == 0);
      automatic logic [3:0] din  = 4'($urandom_range(0, 15));
      automatic bit         en   = 1'($urandom_range(0, 1));
      automatic bit         up   = 1'($urandom_range(0, 1));
      automatic logic [3:0] mask = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      drive(ce, ld, din, en, up, mask, 0);
    end

    // Realign, then a long run of errors to saturate err_count.
    drive(1, 1, 4'h0, 0, 0, 4'h0, 0);
    repeat (300) drive(1, 0, 4'h0, 1, 1, 4'h1, 0);
    check("err_saturated", 32'(err_count[0]), 32'hFF);
    check("stop_err_held", 32'(err_count[1]), 32'd1);

    // Reset asynchronously while the counter shows 9.
    drive(1, 1, 4'h9, 0, 0, 4'h0, 0);
    drive(1, 0, 4'h0, 0, 0, 4'h0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    data_out = '0;
    model_reset();
    #1;
    compare_all();
    check("reset_outputs", {28'd0, checking, halted}, 32'd0);
    check("reset_err", {24'd0, err_count[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) drive(1, 0, 4'h0, 1, 1, 4'h0, 0);
    check("resume_clean", {24'd0, err_count[0]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
